// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-2 demultiplexer.
package demux_pkg;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int unsigned DEMUX_W_DEF = 8;

  // Upstream ready depends only on the slot the current word is steered to.
  function automatic logic sel_ready(input logic sel, input logic a_can, input logic b_can);
    return (sel == SEL_A) ? a_can : b_can;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register slice; optional drain counter under DEMUX_CNT_EN.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int unsigned W = DEMUX_W_DEF
`ifdef DEMUX_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_accept
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       drain;

  assign valid      = (state == ST_FULL);
  assign drain      = valid && ready;
  assign can_accept = !valid || ready;

  // A load while draining keeps the slot full: the new word simply overwrites.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_FULL;
    end else if (drain) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        data <= load_data;
      end
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux_reg_1to2.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake on all three ports.
// DEMUX_CNT_EN adds per-output transfer counters A_CNT/B_CNT.
module demux_reg_1to2
  import demux_pkg::*;
#(
  parameter int unsigned W     = DEMUX_W_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] DIN,
  input  logic         VALID_IN,
  input  logic         S,
  output logic         READY_IN,
  output logic [W-1:0] A_DATA,
  output logic         A_VALID,
  input  logic         A_READY,
  output logic [W-1:0] B_DATA,
  output logic         B_VALID,
  input  logic         B_READY
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] A_CNT,
  output logic [CNT_W-1:0] B_CNT
`endif
);

  logic a_can;
  logic b_can;
  logic in_fire;
  logic load_a;
  logic load_b;

  assign READY_IN = !RST && sel_ready(S, a_can, b_can);
  assign in_fire  = VALID_IN && READY_IN;
  assign load_a   = in_fire && (S == SEL_A);
  assign load_b   = in_fire && (S == SEL_B);

  demux_out_slot #(
    .W(W)
`ifdef DEMUX_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slot_a (
    .clk        (CLK),
    .rst        (RST),
    .load       (load_a),
    .load_data  (DIN),
    .ready      (A_READY),
    .valid      (A_VALID),
    .data       (A_DATA),
    .can_accept (a_can)
`ifdef DEMUX_CNT_EN
    ,
    .cnt        (A_CNT)
`endif
  );

  demux_out_slot #(
    .W(W)
`ifdef DEMUX_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slot_b (
    .clk        (CLK),
    .rst        (RST),
    .load       (load_b),
    .load_data  (DIN),
    .ready      (B_READY),
    .valid      (B_VALID),
    .data       (B_DATA),
    .can_accept (b_can)
`ifdef DEMUX_CNT_EN
    ,
    .cnt        (B_CNT)
`endif
  );

endmodule

// File: tb/tb_demux_reg_1to2.sv
// Scoreboard bench for demux_reg_1to2; counter checks compile in with DEMUX_CNT_EN.
module tb_demux_reg_1to2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIN = '0;
  logic       VALID_IN = 1'b0;
  logic       S = 1'b0;
  logic       READY_IN;
  logic [7:0] A_DATA;
  logic       A_VALID;
  logic       A_READY = 1'b1;
  logic [7:0] B_DATA;
  logic       B_VALID;
  logic       B_READY = 1'b1;
`ifdef DEMUX_CNT_EN
  logic [7:0] A_CNT;
  logic [7:0] B_CNT;
`endif

  demux_reg_1to2 #(.W(8), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .VALID_IN (VALID_IN),
    .S        (S),
    .READY_IN (READY_IN),
    .A_DATA   (A_DATA),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .B_DATA   (B_DATA),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY)
`ifdef DEMUX_CNT_EN
    ,
    .A_CNT    (A_CNT),
    .B_CNT    (B_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stall_cycles = 0;
  int unsigned a_drains = 0;
  int unsigned b_drains = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] m_cnt_a = '0;
  logic [7:0] m_cnt_b = '0;

  logic       hold_a = 1'b0;
  logic       hold_b = 1'b0;
  logic [7:0] hold_a_data = '0;
  logic [7:0] hold_b_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: inputs are stable around the negedge, so this sees the values of the next posedge.
  always @(negedge CLK) begin
    if (RST) begin
      q_a.delete();
      q_b.delete();
      m_cnt_a = '0;
      m_cnt_b = '0;
      hold_a  = 1'b0;
      hold_b  = 1'b0;
    end else begin
      if (hold_a) begin
        check("a_stable_valid", {31'd0, A_VALID}, 32'd1);
        check("a_stable_data", {24'd0, A_DATA}, {24'd0, hold_a_data});
      end
      if (hold_b) begin
        check("b_stable_valid", {31'd0, B_VALID}, 32'd1);
        check("b_stable_data", {24'd0, B_DATA}, {24'd0, hold_b_data});
      end
`ifdef DEMUX_CNT_EN
      check("a_cnt_track", {24'd0, A_CNT}, {24'd0, m_cnt_a});
      check("b_cnt_track", {24'd0, B_CNT}, {24'd0, m_cnt_b});
`endif
      if (A_VALID && A_READY) begin
        a_drains++;
        m_cnt_a = m_cnt_a + 8'd1;
        if (q_a.size() == 0) check("a_unexpected", {24'd0, A_DATA}, 32'hFFFF_FFFF);
        else check("a_data", {24'd0, A_DATA}, {24'd0, q_a.pop_front()});
      end
      if (B_VALID && B_READY) begin
        b_drains++;
        m_cnt_b = m_cnt_b + 8'd1;
        if (q_b.size() == 0) check("b_unexpected", {24'd0, B_DATA}, 32'hFFFF_FFFF);
        else check("b_data", {24'd0, B_DATA}, {24'd0, q_b.pop_front()});
      end
      if (VALID_IN && READY_IN) begin
        if (S) q_a.push_back(DIN);
        else q_b.push_back(DIN);
      end
      hold_a      = A_VALID && !A_READY;
      hold_b      = B_VALID && !B_READY;
      hold_a_data = A_DATA;
      hold_b_data = B_DATA;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge with VALID_IN low.
  task automatic send(input logic [7:0] d, input logic sel);
    int unsigned n;
    n = 0;
    VALID_IN = 1'b1;
    DIN      = d;
    S        = sel;
    @(negedge CLK);
    while (!READY_IN && n < 50) begin
      n++;
      @(negedge CLK);
    end
    stall_cycles += n;
    if (!READY_IN) check("send_timeout", {31'd0, READY_IN}, 32'd1);
    step();
    VALID_IN = 1'b0;
    DIN      = 8'($urandom);
    S        = 1'($urandom);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    VALID_IN = 1'b1;
    DIN      = 8'hFF;
    S        = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("ready_in_rst", {31'd0, READY_IN}, 32'd0);
      step();
    end
    RST      = 1'b0;
    VALID_IN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a0;
    int unsigned b0;
    step();

    // 1: reset
    do_reset();
    @(negedge CLK);
    check("rst_a_valid", {31'd0, A_VALID}, 32'd0);
    check("rst_b_valid", {31'd0, B_VALID}, 32'd0);
    check("rst_a_data", {24'd0, A_DATA}, 32'd0);
    check("rst_b_data", {24'd0, B_DATA}, 32'd0);
`ifdef DEMUX_CNT_EN
    check("rst_a_cnt", {24'd0, A_CNT}, 32'd0);
    check("rst_b_cnt", {24'd0, B_CNT}, 32'd0);
`endif
    step();

    // 2: basic routing, one-cycle latency, one-cycle pulses
    VALID_IN = 1'b1; DIN = 8'h11; S = 1'b1;
    @(negedge CLK);
    check("t2_ready", {31'd0, READY_IN}, 32'd1);
    step();
    DIN = 8'h22; S = 1'b0;
    @(negedge CLK);
    check("t2_a_valid", {31'd0, A_VALID}, 32'd1);
    check("t2_a_data", {24'd0, A_DATA}, 32'h11);
    check("t2_b_idle", {31'd0, B_VALID}, 32'd0);
    step();
    VALID_IN = 1'b0;
    @(negedge CLK);
    check("t2_a_pulse", {31'd0, A_VALID}, 32'd0);
    check("t2_b_valid", {31'd0, B_VALID}, 32'd1);
    check("t2_b_data", {24'd0, B_DATA}, 32'h22);
    step();
    @(negedge CLK);
    check("t2_b_pulse", {31'd0, B_VALID}, 32'd0);
    check("t2_a_hold_data", {24'd0, A_DATA}, 32'h11);
    step();

    // 3: backpressure, then simultaneous drain and refill
    A_READY = 1'b0;
    send(8'h33, 1'b1);
    VALID_IN = 1'b1; DIN = 8'h44; S = 1'b1;
    @(negedge CLK);
    check("t3_ready_blocked", {31'd0, READY_IN}, 32'd0);
    check("t3_a_data", {24'd0, A_DATA}, 32'h33);
    step();
    @(negedge CLK);
    check("t3_ready_blocked2", {31'd0, READY_IN}, 32'd0);
    A_READY = 1'b1;
    #1;
    check("t3_ready_open", {31'd0, READY_IN}, 32'd1);
    step();
    VALID_IN = 1'b0;
    A_READY  = 1'b0;
    @(negedge CLK);
    check("t3_a_valid_kept", {31'd0, A_VALID}, 32'd1);
    check("t3_a_refill", {24'd0, A_DATA}, 32'h44);
    step();

    // 4: B path accepts while A is full and stalled
    VALID_IN = 1'b1; DIN = 8'h55; S = 1'b0;
    @(negedge CLK);
    check("t4_ready", {31'd0, READY_IN}, 32'd1);
    step();
    VALID_IN = 1'b0;
    S = 1'b1;
    @(negedge CLK);
    check("t4_b_valid", {31'd0, B_VALID}, 32'd1);
    check("t4_b_data", {24'd0, B_DATA}, 32'h55);
    check("t4_a_data", {24'd0, A_DATA}, 32'h44);
    check("t4_ready_sel_a", {31'd0, READY_IN}, 32'd0);
    A_READY = 1'b1;
    step();
    step();

    // 5: streaming, alternating paths
    do_reset();
    a0 = a_drains;
    b0 = b_drains;
    stall_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      send(8'(i) ^ 8'h5A, i[0]);
    end
    step();
    step();
    @(negedge CLK);
    check("t5_stalls", stall_cycles, 32'd0);
    check("t5_a_drains", a_drains - a0, 32'd128);
    check("t5_b_drains", b_drains - b0, 32'd128);
    check("t5_q_a_empty", q_a.size(), 32'd0);
    check("t5_q_b_empty", q_b.size(), 32'd0);
`ifdef DEMUX_CNT_EN
    check("t5_a_cnt", {24'd0, A_CNT}, 32'd128);
    check("t5_b_cnt", {24'd0, B_CNT}, 32'd128);
`endif
    step();

    // 6: 256 drains on A, then reset with A full
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(8'($urandom), 1'b1);
    end
    step();
    @(negedge CLK);
`ifdef DEMUX_CNT_EN
    check("t6_a_cnt_255", {24'd0, A_CNT}, 32'd255);
`endif
    check("t6_q_a_empty", q_a.size(), 32'd0);
    step();
    send(8'hA5, 1'b1);
    step();
    @(negedge CLK);
`ifdef DEMUX_CNT_EN
    check("t6_a_cnt_wrap", {24'd0, A_CNT}, 32'd0);
`endif
    check("t6_a_idle", {31'd0, A_VALID}, 32'd0);
    step();
    A_READY = 1'b0;
    send(8'h77, 1'b1);
    A_READY  = 1'b1;
    RST      = 1'b1;
    VALID_IN = 1'b1; DIN = 8'h88; S = 1'b1;
    @(negedge CLK);
    check("t6_ready_rst", {31'd0, READY_IN}, 32'd0);
    step();
    RST      = 1'b0;
    VALID_IN = 1'b0;
    @(negedge CLK);
    check("t6_a_valid_rst", {31'd0, A_VALID}, 32'd0);
    check("t6_b_valid_rst", {31'd0, B_VALID}, 32'd0);
    check("t6_a_data_rst", {24'd0, A_DATA}, 32'd0);
`ifdef DEMUX_CNT_EN
    check("t6_a_cnt_rst", {24'd0, A_CNT}, 32'd0);
`endif
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_reg_1to2.md
Name: demux_reg_1to2

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake; the routing counterpart of the team's 2:1 select mux.
- Steers one input word stream to output A (S=1) or output B (S=0).
- Each output is a one-entry register slot, so a stalled output never corrupts the other path.
- Sits between a single producer and two consumer pipelines.

Parameters:
- W, 8, data width in bits.
- CNT_W, 8, width of per-output transfer counters (used only with DEMUX_CNT_EN).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  W  input data word.
- VALID_IN  input  1  DIN valid.
- S  input  1  route select: 1 = output A, 0 = output B; sampled with DIN.
- READY_IN  output  1  block accepts DIN this cycle.
- A_DATA  output  W  output A data.
- A_VALID  output  1  A_DATA valid.
- A_READY  input  1  consumer A accepts.
- B_DATA  output  W  output B data.
- B_VALID  output  1  B_DATA valid.
- B_READY  input  1  consumer B accepts.
- A_CNT  output  CNT_W  transfers completed on A (present only with DEMUX_CNT_EN).
- B_CNT  output  CNT_W  transfers completed on B (present only with DEMUX_CNT_EN).

Behaviour:
- Reset: RST high at a clock edge clears both slots. After reset: A_VALID=0, B_VALID=0, A_DATA=0, B_DATA=0, counters=0.
- READY_IN is 0 while RST is high.
- Slot state per output, two states:
  - EMPTY -> FULL on accept-into-slot.
  - FULL -> EMPTY on drain without refill.
  - FULL -> FULL on simultaneous drain and refill.
- Input transfer: VALID_IN && READY_IN at a rising edge.
- Output drain: X_VALID && X_READY at a rising edge.
- READY_IN = S ? (!A_full || A_READY) : (!B_full || B_READY).
  - Combinational in S and the selected downstream READY.
  - The unselected path does not affect READY_IN.
- Accepted word is written to the selected slot's DATA register at the accepting edge. X_VALID rises the same edge.
- Latency: exactly 1 cycle from input transfer to X_VALID=1.
- Throughput: 1 word/cycle per path when the consumer holds READY high.
- Simultaneous drain and refill of the same slot: the new word replaces the old; VALID stays 1; no bubble.
- Independent paths: A may drain while an input is accepted into B in the same cycle. Both actions occur.
- Stability rules:
  - X_DATA/X_VALID never change while X_VALID=1 && X_READY=0.
  - DIN and S are ignored when VALID_IN=0.
- S may change every cycle; the routing decision is per accepted word.
- X_DATA holds its last value after drain; it is not cleared.
- Reset mid-operation: slot contents are discarded with no partial drain. A word presented during reset is not accepted.
- No reordering within a path. No ordering guarantee between A and B.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - A_CNT/B_CNT ports exist.
  - Each increments by 1 on its output drain.
  - Wraps modulo 2^CNT_W (255 -> 0 at CNT_W=8).
  - Cleared by RST.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - localparam SEL_A = 1'b1, SEL_B = 1'b0.
  - Default width constant DEMUX_W_DEF = 8.
- Sub-module demux_out_slot: one-entry valid/ready register slice, instantiated twice.
  - Inputs: load, data, drain-ready.
  - Outputs: full/valid, data, can_accept.
  - Holds the optional counter under DEMUX_CNT_EN.

Test Plan:
1. Reset: assert RST 2 cycles with VALID_IN=1, DIN=8'hFF, S=1 -> READY_IN=0; after release A_VALID=B_VALID=0, A_DATA=B_DATA=0, counters=0.
2. Basic routing: send 8'h11 (S=1) then 8'h22 (S=0), both READYs high -> A_VALID pulses 1 cycle with 8'h11 one cycle after accept; B_VALID pulses with 8'h22 the next cycle.
3. Backpressure: A_READY=0, send 8'h33 (S=1) then 8'h44 (S=1) -> first accepted; READY_IN=0 for second; A_DATA holds 8'h33 stable. Raise A_READY -> 8'h33 drains, 8'h44 accepted the same edge, A_VALID stays 1.
4. Independent path: A full and stalled, send 8'h55 (S=0) -> READY_IN=1, B_DATA=8'h55 next cycle, A unchanged.
5. Streaming: 256 back-to-back words alternating S, READYs high -> zero bubbles, per-path order preserved. With DEMUX_CNT_EN, A_CNT=B_CNT=128 mod 256 = 128.
6. Counter wrap (DEMUX_CNT_EN, CNT_W=8): 256 drains on A -> A_CNT returns to 0; RST mid-stream with A full -> A_VALID=0 next cycle, A_CNT=0.
